// File: rtl/lifo_pkt_reader_if.sv
// Bundle of command, LIFO read-port and packet-stream signals around lifo_pkt_reader.
// master is the reader's view; slave is the view of whatever surrounds it.
interface lifo_pkt_reader_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8
);
  logic              cmd_valid_i;
  logic [AWIDTH:0]   cmd_len_i;
  logic              cmd_ready_o;
  logic              lifo_rdreq_o;
  logic [DWIDTH-1:0] lifo_q_i;
  logic              lifo_empty_i;
  logic [AWIDTH:0]   lifo_usedw_i;
  logic [DWIDTH-1:0] data_o;
  logic              valid_o;
  logic              ready_i;
  logic              sop_o;
  logic              eop_o;
  logic              busy_o;
  logic              empty_cmd_o;

  modport master (
    input  cmd_valid_i, cmd_len_i, lifo_q_i, lifo_empty_i, lifo_usedw_i, ready_i,
    output cmd_ready_o, lifo_rdreq_o, data_o, valid_o, sop_o, eop_o, busy_o, empty_cmd_o
  );

  modport slave (
    output cmd_valid_i, cmd_len_i, lifo_q_i, lifo_empty_i, lifo_usedw_i, ready_i,
    input  cmd_ready_o, lifo_rdreq_o, data_o, valid_o, sop_o, eop_o, busy_o, empty_cmd_o
  );
endinterface

// File: rtl/lifo_pkt_reader.sv
// Pops up to N words from a LIFO and emits them as a valid/ready packet with sop/eop.
// state   | meaning
// S_IDLE  | waiting for a length command; cmd_ready high
// S_DRAIN | issuing pops and emitting the packet until the eop handshake
module lifo_pkt_reader #(
  parameter int DWIDTH     = 16,
  parameter int AWIDTH     = 8,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              srst_n_i,
  lifo_pkt_reader_if.master bus
);
  localparam int CW = AWIDTH + 1;
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam int LW = $clog2(BUF_DEPTH + RD_LATENCY + 1);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     rd_left_q, out_left_q, len;
  logic [RD_LATENCY-1:0] inflight_q;
  logic [DWIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]     occ_q;
  logic [LW-1:0]     level;
  logic              first_q, empty_cmd_q;
  logic              accept, cmd_ready, busy;
  logic              rdreq, ret, valid, pop, has_room;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Requests in flight count against buffer space so a returning word always has a slot.
  always_comb begin
    level = LW'(occ_q);
    for (int i = 0; i < RD_LATENCY; i++) level = level + LW'(inflight_q[i]);
  end

  assign has_room = level < LW'(BUF_DEPTH);
  assign ret      = inflight_q[RD_LATENCY-1];
  assign valid    = occ_q != '0;
  assign pop      = valid & bus.ready_i;
  assign len      = (bus.cmd_len_i == '0 || bus.cmd_len_i > bus.lifo_usedw_i)
                    ? bus.lifo_usedw_i : bus.cmd_len_i;
  assign rdreq    = (state_q == S_DRAIN) & srst_n_i & (rd_left_q != '0)
                    & ~bus.lifo_empty_i & has_room;

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = srst_n_i;
        accept    = bus.cmd_valid_i & srst_n_i;
        if (accept && len != '0) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (pop && out_left_q == CW'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      rd_left_q   <= '0;
      out_left_q  <= '0;
      inflight_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      first_q     <= 1'b0;
      empty_cmd_q <= 1'b0;
    end else begin
      empty_cmd_q <= accept && (len == '0);
      if (accept && len != '0) begin
        rd_left_q  <= len;
        out_left_q <= len;
        first_q    <= 1'b1;
      end else begin
        if (rdreq) rd_left_q <= rd_left_q - 1'b1;
        if (pop && out_left_q != '0) out_left_q <= out_left_q - 1'b1;
        if (pop) first_q <= 1'b0;
      end
      inflight_q[0] <= rdreq;
      for (int i = 1; i < RD_LATENCY; i++) inflight_q[i] <= inflight_q[i-1];
      if (ret) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({ret, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (ret) mem[wr_ptr_q] <= bus.lifo_q_i;
  end

  assign bus.data_o       = valid ? mem[rd_ptr_q] : '0;
  assign bus.valid_o      = valid;
  assign bus.sop_o        = first_q & valid;
  assign bus.eop_o        = (out_left_q == CW'(1)) & valid;
  assign bus.busy_o       = busy;
  assign bus.cmd_ready_o  = cmd_ready;
  assign bus.lifo_rdreq_o = rdreq;
  assign bus.empty_cmd_o  = empty_cmd_q;
endmodule

// File: tb/tb_lifo_pkt_reader.sv
// Bench for lifo_pkt_reader: behavioural LIFO, stack-based packet reference, table plus random runs.
module tb_lifo_pkt_reader;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int BD = 4;

  logic clk = 1'b0;
  logic srst_n = 1'b0;
  always #5 clk = ~clk;

  lifo_pkt_reader_if #(.DWIDTH(DW), .AWIDTH(AW)) bus();

  lifo_pkt_reader #(.DWIDTH(DW), .AWIDTH(AW), .RD_LATENCY(1), .BUF_DEPTH(BD)) dut (
    .clk_i   (clk),
    .srst_n_i(srst_n),
    .bus     (bus)
  );

  // Behavioural LIFO with one cycle of read latency.
  logic [DW-1:0] stack [256];
  logic [8:0]    sp = '0;
  logic [DW-1:0] q_reg = '0;
  logic          push_en = 1'b0;
  logic [DW-1:0] push_data = '0;

  always @(posedge clk) begin
    if (push_en) begin
      stack[sp[7:0]] <= push_data;
      sp <= sp + 9'd1;
    end else if (bus.lifo_rdreq_o && sp != 9'd0) begin
      q_reg <= stack[sp[7:0] - 8'd1];
      sp <= sp - 9'd1;
    end
  end

  assign bus.lifo_q_i     = q_reg;
  assign bus.lifo_empty_i = (sp == 9'd0);
  assign bus.lifo_usedw_i = sp;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
    int            cyc;
  } rec_t;

  rec_t mon_q[$];
  int   ec_q[$];
  int   rdreq_cnt = 0, stab_err = 0, bound_err = 0, iss = 0, acc = 0;
  logic pv = 1'b0, pr = 1'b0, ps = 1'b0, pe = 1'b0;
  logic [DW-1:0] pd = '0;

  always @(negedge clk) begin
    if (bus.lifo_rdreq_o) rdreq_cnt <= rdreq_cnt + 1;
    if (!srst_n) begin
      iss <= 0;
      acc <= 0;
      pv  <= 1'b0;
    end else begin
      if (iss - acc > BD) bound_err <= bound_err + 1;
      if (bus.lifo_rdreq_o) iss <= iss + 1;
      if (bus.valid_o && bus.ready_i) begin
        acc <= acc + 1;
        mon_q.push_back('{bus.data_o, bus.sop_o, bus.eop_o, cyc});
      end
      if (bus.empty_cmd_o) ec_q.push_back(cyc);
      if (pv && !pr && !(bus.valid_o && bus.data_o == pd && bus.sop_o == ps && bus.eop_o == pe))
        stab_err <= stab_err + 1;
      pv <= bus.valid_o;
      pr <= bus.ready_i;
      pd <= bus.data_o;
      ps <= bus.sop_o;
      pe <= bus.eop_o;
    end
  end

  typedef struct {
    int            n_push;
    logic [DW-1:0] base;
    logic [DW-1:0] stepv;
    int            len;
    int            exp_n;
    bit            exp_ec;
    int            exp_left;
  } vec_t;

  vec_t          tbl[7];
  logic [DW-1:0] ref_q[$];
  int            tests = 0, fails = 0;
  bit            rand_rdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.ready_i = ($urandom_range(0, 1) == 1);
  endtask

  task automatic push(input logic [DW-1:0] v);
    push_en   = 1'b1;
    push_data = v;
    step();
    push_en = 1'b0;
    ref_q.push_back(v);
  endtask

  task automatic run_cmd(input int len, input int exp_n, input bit exp_ec, input bit chk_t,
                         input string tag);
    int b, eb, r0, a, sop_bad, eop_bad, n;
    bit done, bad;
    logic [DW-1:0] e;
    b  = mon_q.size();
    eb = ec_q.size();
    r0 = rdreq_cnt;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_len_i   = len[AW:0];
    @(negedge clk);
    check({tag, "_cmd_ready"}, bus.cmd_ready_o, 1);
    a = cyc;
    step();
    bus.cmd_valid_i = 1'b0;
    if (exp_n == 0) begin
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (!bus.cmd_ready_o || bus.valid_o || bus.busy_o || bus.lifo_rdreq_o) bad = 1'b1;
        step();
      end
      check({tag, "_idle_quiet"}, bad, 0);
      check({tag, "_empty_cmd_cnt"}, ec_q.size() - eb, exp_ec ? 1 : 0);
      if (ec_q.size() > eb) check({tag, "_empty_cmd_cyc"}, ec_q[eb], a + 1);
      check({tag, "_no_words"}, mon_q.size() - b, 0);
      check({tag, "_no_rdreq"}, rdreq_cnt - r0, 0);
    end else begin
      done = 1'b0;
      for (int k = 0; k < 3000 && !done; k++) begin
        step();
        if (mon_q.size() > b && mon_q[mon_q.size()-1].eop) done = 1'b1;
      end
      check({tag, "_done_in_budget"}, done, 1);
      check({tag, "_ready_after_eop"}, bus.cmd_ready_o, 1);
      check({tag, "_busy_after_eop"}, bus.busy_o, 0);
      n = mon_q.size() - b;
      check({tag, "_word_count"}, n, exp_n);
      check({tag, "_rdreq_count"}, rdreq_cnt - r0, exp_n);
      check({tag, "_no_empty_cmd"}, ec_q.size() - eb, 0);
      sop_bad = 0;
      eop_bad = 0;
      for (int i = 0; i < exp_n; i++) begin
        if (ref_q.size() == 0) break;
        e = ref_q.pop_back();
        if (i < n) begin
          check({tag, "_word"}, mon_q[b+i].d, e);
          if (mon_q[b+i].sop != (i == 0)) sop_bad++;
          if (mon_q[b+i].eop != (i == exp_n - 1)) eop_bad++;
        end
      end
      check({tag, "_sop_marks"}, sop_bad, 0);
      check({tag, "_eop_marks"}, eop_bad, 0);
      if (chk_t && n > 0) begin
        check({tag, "_first_cyc"}, mon_q[b].cyc, a + 3);
        check({tag, "_last_cyc"}, mon_q[b+n-1].cyc, a + 2 + exp_n);
      end
    end
  endtask

  initial begin
    int b, r0, popped, len, exp_n, n;
    logic [DW-1:0] v;

    tbl[0] = '{5, 16'h0001, 16'h0001, 5, 5, 1'b0, 0};
    tbl[1] = '{3, 16'hAAAA, 16'h1111, 0, 3, 1'b0, 0};
    tbl[2] = '{4, 16'h0001, 16'h0001, 10, 4, 1'b0, 0};
    tbl[3] = '{0, 16'h0000, 16'h0000, 5, 0, 1'b1, 0};
    tbl[4] = '{6, 16'h0100, 16'h0001, 2, 2, 1'b0, 4};
    tbl[5] = '{0, 16'h0000, 16'h0000, 1, 1, 1'b0, 3};
    tbl[6] = '{0, 16'h0000, 16'h0000, 0, 3, 1'b0, 0};

    bus.cmd_valid_i = 1'b0;
    bus.cmd_len_i   = '0;
    bus.ready_i     = 1'b0;
    srst_n = 1'b0;
    step();
    step();
    @(negedge clk);
    check("rst_valid", bus.valid_o, 0);
    check("rst_sop", bus.sop_o, 0);
    check("rst_eop", bus.eop_o, 0);
    check("rst_rdreq", bus.lifo_rdreq_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_empty_cmd", bus.empty_cmd_o, 0);
    check("rst_data", bus.data_o, 0);
    check("rst_cmd_ready_low", bus.cmd_ready_o, 0);
    step();
    srst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready_released", bus.cmd_ready_o, 1);
    step();

    bus.ready_i = 1'b1;
    for (int t = 0; t < 7; t++) begin
      v = tbl[t].base;
      for (int i = 0; i < tbl[t].n_push; i++) begin
        push(v);
        v = v + tbl[t].stepv;
      end
      run_cmd(tbl[t].len, tbl[t].exp_n, tbl[t].exp_ec, tbl[t].exp_n > 0, $sformatf("tbl%0d", t));
      check($sformatf("tbl%0d_lifo_left", t), sp, tbl[t].exp_left);
    end

    // Reset in the middle of a 10-word packet.
    for (int i = 0; i < 10; i++) push(DW'(16'h5000 + i));
    b  = mon_q.size();
    r0 = rdreq_cnt;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_len_i   = 9'd10;
    step();
    bus.cmd_valid_i = 1'b0;
    for (int k = 0; k < 50 && (mon_q.size() - b) < 3; k++) step();
    srst_n = 1'b0;
    bus.ready_i = 1'b0;
    @(negedge clk);
    check("mid_rst_cmd_ready_low", bus.cmd_ready_o, 0);
    step();
    srst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", bus.valid_o, 0);
    check("mid_rst_busy", bus.busy_o, 0);
    check("mid_rst_sop", bus.sop_o, 0);
    check("mid_rst_cmd_ready", bus.cmd_ready_o, 1);
    step();
    n = mon_q.size() - b;
    check("mid_rst_words_before", n >= 3, 1);
    for (int i = 0; i < 3 && i < n && i < ref_q.size(); i++)
      check("mid_rst_word", mon_q[b+i].d, ref_q[ref_q.size()-1-i]);
    popped = rdreq_cnt - r0;
    for (int i = 0; i < popped && ref_q.size() > 0; i++) void'(ref_q.pop_back());
    check("mid_rst_lifo_level", sp, ref_q.size());
    bus.ready_i = 1'b1;
    step();
    run_cmd(0, ref_q.size(), ref_q.size() == 0, 1, "after_rst");

    // Random commands against the stack reference.
    rand_rdy = 1'b1;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) push(DW'($urandom));
      len   = $urandom_range(0, 20);
      exp_n = (len == 0 || len > ref_q.size()) ? ref_q.size() : len;
      run_cmd(len, exp_n, exp_n == 0, 0, $sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_lifo_left", r), sp, ref_q.size());
    end

    // Full-depth drain with random backpressure.
    rand_rdy = 1'b0;
    bus.ready_i = 1'b1;
    step();
    run_cmd(0, ref_q.size(), ref_q.size() == 0, 0, "pre_full");
    for (int i = 0; i < 256; i++) push(DW'($urandom));
    check("full_usedw", sp, 256);
    rand_rdy = 1'b1;
    run_cmd(0, 256, 0, 0, "full");
    check("full_lifo_empty", sp, 0);
    rand_rdy = 1'b0;
    step();

    check("stall_stable", stab_err, 0);
    check("buffer_bound", bound_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lifo_pkt_reader.md
# lifo_pkt_reader

Drain stage placed directly downstream of `lifo`. On a length command it pops up to N words from the LIFO via `rdreq`/`q`, absorbs the LIFO read latency in a small credit-controlled buffer, and presents the words as a valid/ready packet with start/end markers. Words leave in pop order, top of stack first, so each packet is the write order reversed.

## Interface
- DWIDTH, 16, data word width; matches `lifo` DWIDTH
- AWIDTH, 8, LIFO address width; LIFO depth is 2**AWIDTH
- RD_LATENCY, 1, cycles from `lifo_rdreq_o` high to valid `lifo_q_i`
- BUF_DEPTH, 4, output buffer entries; must be >= RD_LATENCY+2

Ports:
- clk_i  in  1  clock; all logic on rising edge
- srst_n_i  in  1  reset; synchronous, active-low
- cmd_valid_i  in  1  drain command request
- cmd_len_i  in  AWIDTH+1  requested word count; 0 means drain everything
- cmd_ready_o  out  1  command accepted when both valid and ready are high
- lifo_rdreq_o  out  1  pop request to `lifo`
- lifo_q_i  in  DWIDTH  `lifo` read data
- lifo_empty_i  in  1  `lifo` empty flag
- lifo_usedw_i  in  AWIDTH+1  `lifo` fill level
- data_o  out  DWIDTH  packet word
- valid_o  out  1  `data_o` is valid
- ready_i  in  1  downstream accepts a word when both valid and ready are high
- sop_o  out  1  first word of the packet; qualified by `valid_o`
- eop_o  out  1  last word of the packet; qualified by `valid_o`
- busy_o  out  1  packet in progress; upstream must not write the LIFO while high
- empty_cmd_o  out  1  one-cycle pulse: command accepted while the LIFO was empty

## Operation
- States: IDLE, DRAIN.
- IDLE:
  - `cmd_ready_o`=1.
  - On command handshake: `len` = (`cmd_len_i`==0 or `cmd_len_i`>`lifo_usedw_i`) ? `lifo_usedw_i` : `cmd_len_i`.
  - If `len`==0: pulse `empty_cmd_o` and stay in IDLE.
  - Otherwise load `rd_left`=`len` and `out_left`=`len`, then go to DRAIN.
- DRAIN:
  - `cmd_ready_o`=0 and `busy_o`=1.
  - `lifo_rdreq_o` is combinational: DRAIN & `rd_left`!=0 & !`lifo_empty_i` & (`inflight`+`occupancy`) < BUF_DEPTH.
  - `inflight` is an RD_LATENCY-deep shift register of issued reads. Each returning word is written into the buffer.
  - The buffer head drives `data_o`. `valid_o` = `occupancy`!=0.
  - `sop_o` is high on the first word emitted after command accept. `eop_o` = (`out_left`==1) & `valid_o`.
  - A pop on handshake decrements `out_left`. The `eop_o` handshake returns the state to IDLE.
- `lifo_empty_i` high in DRAIN with `rd_left`!=0 is a protocol violation (upstream wrote or reset the LIFO). The block stalls issuing reads; recovery is by reset only.
- Counters are AWIDTH+1 bits wide, so a length of 2**AWIDTH is legal. There is no wrap: counters never decrement below 0.
- Simultaneous buffer write and pop in one cycle leaves `occupancy` unchanged.

## Timing
- Reset (`srst_n_i`=0 at an edge):
  - Outputs: `valid_o`, `sop_o`, `eop_o`, `lifo_rdreq_o`, `busy_o`, `empty_cmd_o` = 0; `data_o`='0.
  - `cmd_ready_o`=0 while `srst_n_i` is low.
  - Next state is IDLE. `inflight`, `occupancy` and counters clear, and in-flight read data is discarded.
- Command handshake in cycle A:
  - First `lifo_rdreq_o` in A+1.
  - `lifo_q_i` is captured at the end of A+1+RD_LATENCY.
  - First `valid_o` in A+2+RD_LATENCY (A+3 for the default).
- With `ready_i` held high: one word per cycle, no bubbles, N words end at cycle A+1+RD_LATENCY+N.
- `cmd_ready_o` returns to 1 in the cycle after the `eop_o` handshake.
- `empty_cmd_o` pulses in A+1.
- While `valid_o`=1 and `ready_i`=0: `data_o`, `sop_o`, `eop_o` hold stable.
- `lifo_rdreq_o` is never asserted when a returning word could overflow the buffer.

## Test plan
- Write 1,2,3,4,5; `cmd_len_i`=5, `ready_i`=1 → `data_o` 5,4,3,2,1 in consecutive cycles starting at A+3; `sop_o` on 5, `eop_o` on 1; `empty_cmd_o` never pulses.
- Write 16'hAAAA,16'hBBBB,16'hCCCC; `cmd_len_i`=0 → 3 words CCCC,BBBB,AAAA; LIFO empty afterwards.
- `usedw`=4 (values 1..4); `cmd_len_i`=10 → exactly 4 words 4,3,2,1 with `eop_o` on 1; exactly 4 rdreq pulses.
- Empty LIFO, command with `cmd_len_i`=5 → `empty_cmd_o` pulse at A+1, no `valid_o`, no `lifo_rdreq_o`, `cmd_ready_o` stays 1.
- Fill 2**AWIDTH words, `cmd_len_i`=0, `ready_i` random 50% → 256 words, exact reverse order, no loss or duplication; `data_o` stable under stall; `inflight`+`occupancy` ≤ BUF_DEPTH throughout.
- `srst_n_i` low for 1 cycle after 3 words of a 10-word packet → `valid_o`=0 and `busy_o`=0 next cycle; `cmd_ready_o`=1 once reset is released; a following command produces a correct packet with `sop_o`.
